// File: rtl/dcl_pkg.sv
// rtl/dcl_pkg.sv - shared constants, state enum and helpers for bcd_scan_display
package dcl_pkg;

  localparam logic [6:0] SEG7_0     = 7'b1111110;
  localparam logic [6:0] SEG7_1     = 7'b0110000;
  localparam logic [6:0] SEG7_2     = 7'b1101101;
  localparam logic [6:0] SEG7_3     = 7'b1111001;
  localparam logic [6:0] SEG7_4     = 7'b0110011;
  localparam logic [6:0] SEG7_5     = 7'b1011011;
  localparam logic [6:0] SEG7_6     = 7'b1011111;
  localparam logic [6:0] SEG7_7     = 7'b1110000;
  localparam logic [6:0] SEG7_8     = 7'b1111111;
  localparam logic [6:0] SEG7_9     = 7'b1111011;
  localparam logic [6:0] SEG7_BLANK = 7'b0000000;

  localparam logic [7:0] DIGSEL_0 = 8'b0000_0001;
  localparam logic [7:0] DIGSEL_1 = 8'b0000_0010;
  localparam logic [7:0] DIGSEL_2 = 8'b0000_0100;
  localparam logic [7:0] DIGSEL_3 = 8'b0000_1000;

  localparam logic [15:0] BIN_MAX = 16'd9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg7_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG7_0;
      4'd1:    s = SEG7_1;
      4'd2:    s = SEG7_2;
      4'd3:    s = SEG7_3;
      4'd4:    s = SEG7_4;
      4'd5:    s = SEG7_5;
      4'd6:    s = SEG7_6;
      4'd7:    s = SEG7_7;
      4'd8:    s = SEG7_8;
      4'd9:    s = SEG7_9;
      default: s = SEG7_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: any nibble >= 5 would overflow a decade after the shift.
  function automatic logic [15:0] bcd_add3(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// rtl/bcd_scan_display_if.sv - load/status bundle between the meter and the display stage
interface bcd_scan_display_if;
  logic        load;
  logic [15:0] value;
  logic [1:0]  dp_pos;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (output load, value, dp_pos, input busy, done, ovf);
  modport slave  (input load, value, dp_pos, output busy, done, ovf);
endinterface

// File: rtl/bin2bcd16_seq.sv
// rtl/bin2bcd16_seq.sv - sequential 16-bit binary to 4-digit BCD converter
// Holds the conversion FSM, the pending-load register, overflow flag and committed digits.
module bin2bcd16_seq
  import dcl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        i_load,
  input  logic [15:0] i_value,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ovf,
  output logic [15:0] o_digits
);

  conv_state_t r_state;
  conv_state_t w_state_nxt;
  logic [15:0] r_bin;
  logic [15:0] r_bcd;
  logic [15:0] r_disp;
  logic [15:0] r_pend_val;
  logic        r_pend;
  logic        r_ovf;
  logic [3:0]  r_step;
  logic        w_start;
  logic [15:0] w_src;
  logic [15:0] w_sat;
  logic [15:0] w_adj;

  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // A load on the DONE cycle starts the next conversion directly; it overrides any older pending value.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_src       = i_load ? i_value : r_pend_val;
    case (r_state)
      IDLE: begin
        if (i_load || r_pend) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
        end
      end
      SHIFT: begin
        if (r_step == 4'd15) w_state_nxt = DONE;
      end
      DONE: begin
        if (i_load || r_pend) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sat = (w_src > BIN_MAX) ? BIN_MAX : w_src;
  assign w_adj = bcd_add3(r_bcd);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_step <= '0;
      r_ovf  <= 1'b0;
    end else if (w_start) begin
      r_bin  <= w_sat;
      r_bcd  <= '0;
      r_step <= '0;
      r_ovf  <= (w_src > BIN_MAX);
    end else if (r_state == SHIFT) begin
      {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
      r_step         <= r_step + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else if (w_start) begin
      r_pend <= 1'b0;
    end else if (i_load && (r_state == SHIFT)) begin
      r_pend     <= 1'b1;
      r_pend_val <= i_value;
    end
  end

  always_ff @(posedge clk) begin
    if (clr)                   r_disp <= '0;
    else if (r_state == DONE)  r_disp <= r_bcd;
  end

  assign o_busy   = (r_state != IDLE);
  assign o_done   = (r_state == DONE);
  assign o_ovf    = r_ovf;
  // Forward the finished accumulator on DONE so the output stage picks it up in the same edge as the commit.
  assign o_digits = (r_state == DONE) ? r_bcd : r_disp;

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - BCD conversion plus 4-digit multiplexed seven-segment scan
// Optional leading-zero blanking under macro LEADING_ZERO_BLANK_EN.
module bcd_scan_display
  import dcl_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                clr,
  bcd_scan_display_if.slave   bus,
  output logic [7:0]          SEG,
  output logic [6:0]          codeout,
  output logic                dot
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [15:0]   w_digits;
  logic [CW-1:0] r_scan_cnt;
  logic [1:0]    r_slot;
  logic [3:0]    w_digit;
  logic [7:0]    w_sel;
  logic          w_blank;
  logic [7:0]    r_seg;
  logic [6:0]    r_code;
  logic          r_dot;

  bin2bcd16_seq u_conv (
    .clk      (clk),
    .clr      (clr),
    .i_load   (bus.load),
    .i_value  (bus.value),
    .o_busy   (bus.busy),
    .o_done   (bus.done),
    .o_ovf    (bus.ovf),
    .o_digits (w_digits)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_scan_cnt <= '0;
      r_slot     <= 2'd0;
    end else if (r_scan_cnt == CNT_LAST) begin
      r_scan_cnt <= '0;
      r_slot     <= r_slot + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + CW'(1);
    end
  end

  always_comb begin
    w_digit = w_digits[15:12];
    w_sel   = DIGSEL_0;
    case (r_slot)
      2'd0: begin w_digit = w_digits[15:12]; w_sel = DIGSEL_0; end
      2'd1: begin w_digit = w_digits[11:8];  w_sel = DIGSEL_1; end
      2'd2: begin w_digit = w_digits[7:4];   w_sel = DIGSEL_2; end
      default: begin w_digit = w_digits[3:0]; w_sel = DIGSEL_3; end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] w_lead_zero;
  // w_lead_zero[s]: slot s and every slot to its left hold 0; the ones slot is never a candidate.
  assign w_lead_zero[0] = (w_digits[15:12] == 4'd0);
  assign w_lead_zero[1] = w_lead_zero[0] && (w_digits[11:8] == 4'd0);
  assign w_lead_zero[2] = w_lead_zero[1] && (w_digits[7:4] == 4'd0);
  assign w_lead_zero[3] = 1'b0;
  assign w_blank = w_lead_zero[r_slot] && (r_slot < bus.dp_pos);
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_seg  <= DIGSEL_0;
      r_code <= SEG7_0;
      r_dot  <= 1'b0;
    end else begin
      r_seg  <= w_sel;
      r_code <= w_blank ? SEG7_BLANK : seg7_encode(w_digit);
      r_dot  <= (r_slot == bus.dp_pos);
    end
  end

  assign SEG     = r_seg;
  assign codeout = r_code;
  assign dot     = r_dot;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - directed vector bench for bcd_scan_display (SCAN_DIV=4)
module tb_bcd_scan_display;

  localparam int SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] SEG;
  logic [6:0] codeout;
  logic       dot;

  bcd_scan_display_if bus ();

  bcd_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .clr     (clr),
    .bus     (bus),
    .SEG     (SEG),
    .codeout (codeout),
    .dot     (dot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] value;
    logic [1:0]  dp;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
    logic [3:0]  blank_mask;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_code(input logic [15:0] bcd, input logic [3:0] mask, input int slot);
    logic [3:0] d;
    d = bcd[15-4*slot -: 4];
    if (BLANK_EN && mask[slot]) return 7'b0000000;
    return seg_of(d);
  endfunction

  task automatic check_disp_cycle(input string tag, input logic [15:0] bcd, input logic [3:0] mask,
                                  input logic [1:0] dp, output logic [3:0] hit);
    int slot;
    slot = -1;
    hit  = 4'b0000;
    case (SEG)
      8'h01: slot = 0;
      8'h02: slot = 1;
      8'h04: slot = 2;
      8'h08: slot = 3;
      default: slot = -1;
    endcase
    n_cmp++;
    if (slot < 0) begin
      n_bad++;
      $display("FAIL %s SEG one-hot: got %b expected one of 01/02/04/08", tag, SEG);
    end else begin
      hit[slot] = 1'b1;
      chk({tag, " codeout"}, 32'(codeout), 32'(exp_code(bcd, mask, slot)));
      chk({tag, " dot"}, 32'(dot), 32'(slot == int'(dp)));
    end
  endtask

  task automatic check_display(input string tag, input logic [15:0] bcd, input logic [3:0] mask,
                               input logic [1:0] dp);
    logic [3:0] seen;
    logic [3:0] hit;
    seen = 4'b0000;
    for (int c = 0; c < 4 * SCAN_DIV; c++) begin
      check_disp_cycle(tag, bcd, mask, dp, hit);
      seen = seen | hit;
      tick();
    end
    chk({tag, " all slots scanned"}, 32'(seen), 32'hF);
  endtask

  task automatic run_vec(input vec_t v);
    string tag;
    tag = $sformatf("vec %0d", v.value);
    bus.value  = v.value;
    bus.dp_pos = v.dp;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk({tag, " busy in shift"}, 32'(bus.busy), 32'd1);
      chk({tag, " done in shift"}, 32'(bus.done), 32'd0);
      tick();
    end
    chk({tag, " done at n+17"}, 32'(bus.done), 32'd1);
    chk({tag, " busy at n+17"}, 32'(bus.busy), 32'd1);
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(v.exp_ovf));
    tick();
    chk({tag, " busy after"}, 32'(bus.busy), 32'd0);
    chk({tag, " done after"}, 32'(bus.done), 32'd0);
    check_display(tag, v.exp_bcd, v.blank_mask, v.dp);
  endtask

  initial begin
    logic [3:0] hit;
    bus.load   = 1'b0;
    bus.value  = 16'd0;
    bus.dp_pos = 2'd3;
    clr        = 1'b1;
    tick();
    tick();
    chk("reset SEG", 32'(SEG), 32'h01);
    chk("reset codeout", 32'(codeout), 32'h7E);
    chk("reset dot", 32'(dot), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset ovf", 32'(bus.ovf), 32'd0);
    clr = 1'b0;

    vecs[0] = '{16'd2573,  2'd2, 16'h2573, 1'b0, 4'b0000};
    vecs[1] = '{16'd12345, 2'd0, 16'h9999, 1'b1, 4'b0000};
    vecs[2] = '{16'd0,     2'd3, 16'h0000, 1'b0, 4'b0111};
    vecs[3] = '{16'd9999,  2'd1, 16'h9999, 1'b0, 4'b0000};
    vecs[4] = '{16'd10000, 2'd3, 16'h9999, 1'b1, 4'b0000};
    vecs[5] = '{16'd5,     2'd2, 16'h0005, 1'b0, 4'b0011};
    vecs[6] = '{16'd1004,  2'd3, 16'h1004, 1'b0, 4'b0000};
    vecs[7] = '{16'd60,    2'd3, 16'h0060, 1'b0, 4'b0011};
    vecs[8] = '{16'd60,    2'd1, 16'h0060, 1'b0, 4'b0001};
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Loads while busy: 42 at n, 7 at n+5, 9 at n+9; only 9 follows 42.
    bus.dp_pos = 2'd3;
    bus.value  = 16'd42;
    bus.load   = 1'b1;
    tick();
    bus.load   = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      chk($sformatf("b2b busy c%0d", c), 32'(bus.busy), 32'd1);
      chk($sformatf("b2b done c%0d", c), 32'(bus.done), 32'((c == 17) || (c == 34)));
      if (c == 17) chk("b2b ovf", 32'(bus.ovf), 32'd0);
      if (c >= 18 && c <= 33) check_disp_cycle("b2b 0042", 16'h0042, 4'b0011, 2'd3, hit);
      if (c == 5)  begin bus.value = 16'd7; bus.load = 1'b1; end
      if (c == 9)  begin bus.value = 16'd9; bus.load = 1'b1; end
      if (c == 6 || c == 10) bus.load = 1'b0;
      tick();
    end
    chk("b2b busy end", 32'(bus.busy), 32'd0);
    check_display("b2b 0009", 16'h0009, 4'b0111, 2'd3);

    // Reset in the middle of a conversion discards it.
    run_vec('{16'd1234, 2'd3, 16'h1234, 1'b0, 4'b0000});
    bus.value = 16'd8;
    bus.load  = 1'b1;
    tick();
    bus.load  = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    chk("abort busy before clr", 32'(bus.busy), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort SEG", 32'(SEG), 32'h01);
    chk("abort codeout", 32'(codeout), 32'h7E);
    chk("abort dot", 32'(dot), 32'd0);
    chk("abort ovf", 32'(bus.ovf), 32'd0);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("abort no done c%0d", c), 32'(bus.done), 32'd0);
      chk($sformatf("abort idle c%0d", c), 32'(bus.busy), 32'd0);
      tick();
    end
    check_display("abort 0000", 16'h0000, 4'b0111, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
